// File: rtl/anita3_event_readout.sv
// Event header readout: queues completed-event buffer numbers, reads each buffer's
// header words from the header RAM, streams them out over valid/ready, then
// pulses a one-hot clear so the hold logic can release the buffer.
module anita3_event_readout #(
  parameter int unsigned NUM_WORDS   = 22,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        event_done_i,
  input  logic [1:0]  event_buffer_i,
  output logic [7:0]  ram_addr_o,
  output logic        ram_rd_o,
  input  logic [15:0] ram_dat_i,
  output logic [15:0] dat_o,
  output logic        valid_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic [3:0]  buffer_clear_o,
  output logic [2:0]  pending_o,
  output logic        overflow_o
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [2:0] Depth = 3'(QUEUE_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(QUEUE_DEPTH - 1);
  localparam logic [5:0] LastWord = 6'(NUM_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StCapture, StOut, StClear} state_t;

  state_t          state;
  logic [5:0]      word;
  logic [1:0]      queue [QUEUE_DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [2:0]      count;
  logic [1:0]      head;
  logic            full;
  logic            push;
  logic            pop;

  assign head       = queue[rd_ptr];
  assign full       = (count == Depth);
  // The head leaves on the CLEAR cycle, so a push in that cycle always has room.
  assign pop        = (state == StClear);
  assign push       = event_done_i && (!full || pop);
  assign pending_o  = count;
  assign ram_addr_o = {head, word};

  // Pending-event FIFO and sticky overflow flag.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        queue[i] <= 2'b00;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 3'd0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        queue[wr_ptr] <= event_buffer_i;
        wr_ptr        <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 3'd1;
      end else if (pop && !push) begin
        count <= count - 3'd1;
      end
      if (event_done_i && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Readout FSM; every output is registered, so strobes are set on entry to their state.
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state          <= StIdle;
      word           <= 6'd0;
      dat_o          <= 16'h0000;
      valid_o        <= 1'b0;
      last_o         <= 1'b0;
      ram_rd_o       <= 1'b0;
      buffer_clear_o <= 4'b0000;
    end else begin
      ram_rd_o       <= 1'b0;
      buffer_clear_o <= 4'b0000;
      case (state)
        StIdle: begin
          word <= 6'd0;
          if (count != 3'd0) begin
            state    <= StFetch;
            ram_rd_o <= 1'b1;
          end
        end
        StFetch: begin
          state <= StCapture;
        end
        StCapture: begin
          dat_o   <= ram_dat_i;
          valid_o <= 1'b1;
          last_o  <= (word == LastWord);
          state   <= StOut;
        end
        StOut: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            if (word == LastWord) begin
              state          <= StClear;
              buffer_clear_o <= 4'b0001 << head;
            end else begin
              word     <= word + 6'd1;
              state    <= StFetch;
              ram_rd_o <= 1'b1;
            end
          end
        end
        StClear: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anita3_event_readout.sv
// Directed bench for anita3_event_readout: a 22-word instance plus a 1-word instance,
// each backed by a synchronous RAM model that returns {addr, addr}.
module tb_anita3_event_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [1:0]  bufn = 2'd0;
  logic        ready = 1'b1;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [15:0] ram_dat = 16'h0000;
  logic [15:0] dat;
  logic        valid;
  logic        last;
  logic [3:0]  clr;
  logic [2:0]  pending;
  logic        overflow;

  logic        done1 = 1'b0;
  logic [1:0]  buf1 = 2'd0;
  logic        ready1 = 1'b1;
  logic [7:0]  addr1;
  logic        rd1;
  logic [15:0] rdat1 = 16'h0000;
  logic [15:0] dat1;
  logic        valid1;
  logic        last1;
  logic [3:0]  clr1;
  logic [2:0]  pending1;
  logic        overflow1;

  int checks = 0;
  int errors = 0;

  logic [16:0] acc_log [$];
  logic [3:0]  clr_log [$];
  int          rd_count = 0;

  always #5 clk = ~clk;

  anita3_event_readout #(.NUM_WORDS(22), .QUEUE_DEPTH(4)) u_dut (
    .clk33_i(clk), .rst_i(rst), .event_done_i(done), .event_buffer_i(bufn),
    .ram_addr_o(ram_addr), .ram_rd_o(ram_rd), .ram_dat_i(ram_dat),
    .dat_o(dat), .valid_o(valid), .last_o(last), .ready_i(ready),
    .buffer_clear_o(clr), .pending_o(pending), .overflow_o(overflow)
  );

  anita3_event_readout #(.NUM_WORDS(1), .QUEUE_DEPTH(4)) u_one (
    .clk33_i(clk), .rst_i(rst), .event_done_i(done1), .event_buffer_i(buf1),
    .ram_addr_o(addr1), .ram_rd_o(rd1), .ram_dat_i(rdat1),
    .dat_o(dat1), .valid_o(valid1), .last_o(last1), .ready_i(ready1),
    .buffer_clear_o(clr1), .pending_o(pending1), .overflow_o(overflow1)
  );

  always @(posedge clk) begin
    if (ram_rd === 1'b1) ram_dat <= {ram_addr, ram_addr};
    if (rd1 === 1'b1) rdat1 <= {addr1, addr1};
  end

  // Log accepted words, read strobes and clear pulses of the main instance.
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) acc_log.push_back({last, dat});
    if (ram_rd === 1'b1) rd_count <= rd_count + 1;
    if (!$isunknown(clr) && clr !== 4'b0000) clr_log.push_back(clr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [1:0] b);
    done = 1'b1;
    bufn = b;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_pending_zero(input int budget, input string name);
    int n;
    n = 0;
    while (pending !== 3'd0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (pending !== 3'd0) begin
      errors++;
      $display("FAIL %s drain timeout: pending %0d required 0", name, pending);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({valid, last, ram_rd, clr, dat, ram_addr, pending, overflow} !== 35'd0) begin
      errors++;
      $display("FAIL reset_main: got %h required 0",
               {valid, last, ram_rd, clr, dat, ram_addr, pending, overflow});
    end
    checks++;
    if ({valid1, last1, rd1, clr1, dat1, addr1, pending1, overflow1} !== 35'd0) begin
      errors++;
      $display("FAIL reset_one: got %h required 0",
               {valid1, last1, rd1, clr1, dat1, addr1, pending1, overflow1});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_event();
    int s, c, r;
    logic [7:0] a;
    logic lst;
    logic [16:0] exp, got;
    ready = 1'b1;
    s = acc_log.size(); c = clr_log.size(); r = rd_count;
    pulse(2'd2);
    checks++;
    if (pending !== 3'd1) begin
      errors++; $display("FAIL ev1_pending: got %0d required 1", pending);
    end
    tick();
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 8'h80) begin
      errors++; $display("FAIL ev1_fetch: rd %b addr %h required 1 80", ram_rd, ram_addr);
    end
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || dat !== 16'h8080 || last !== 1'b0) begin
      errors++;
      $display("FAIL ev1_first_valid: valid %b dat %h last %b required 1 8080 0", valid, dat, last);
    end
    wait_pending_zero(200, "ev1");
    checks++;
    if (acc_log.size() - s != 22) begin
      errors++; $display("FAIL ev1_word_count: got %0d required 22", acc_log.size() - s);
    end
    for (int i = 0; i < 22; i++) begin
      a = 8'(8'h80 + i);
      lst = (i == 21);
      exp = {lst, a, a};
      got = (s + i < acc_log.size()) ? acc_log[s + i] : 17'bx;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ev1_word%0d: got %h required %h", i, got, exp);
      end
    end
    checks++;
    if (rd_count - r != 22) begin
      errors++; $display("FAIL ev1_rd_count: got %0d required 22", rd_count - r);
    end
    checks++;
    if (clr_log.size() - c != 1 || clr_log[c] !== 4'b0100) begin
      errors++; $display("FAIL ev1_clear: pulses %0d required 1 of 0100", clr_log.size() - c);
    end
  endtask

  task automatic test_backpressure();
    int s, c, n;
    ready = 1'b1;
    s = acc_log.size(); c = clr_log.size();
    pulse(2'd2);
    n = 0;
    while (acc_log.size() < s + 5 && n < 200) begin tick(); n++; end
    ready = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin tick(); n++; end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (valid !== 1'b1 || dat !== 16'h8585 || ram_rd !== 1'b0 || last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %b dat %h rd %b last %b required 1 8585 0 0",
                 k, valid, dat, ram_rd, last);
      end
      tick();
    end
    ready = 1'b1;
    wait_pending_zero(200, "bp");
    checks++;
    if (acc_log.size() - s != 22) begin
      errors++; $display("FAIL bp_word_count: got %0d required 22", acc_log.size() - s);
    end
    checks++;
    if (acc_log[s + 5] !== {1'b0, 16'h8585} || acc_log[s + 6] !== {1'b0, 16'h8686}) begin
      errors++;
      $display("FAIL bp_order: got %h %h required 08585 08686", acc_log[s + 5], acc_log[s + 6]);
    end
    checks++;
    if (clr_log.size() - c != 1 || clr_log[c] !== 4'b0100) begin
      errors++; $display("FAIL bp_clear: pulses %0d required 1 of 0100", clr_log.size() - c);
    end
  endtask

  task automatic test_queue_order();
    int s, c;
    logic [7:0] a;
    ready = 1'b1;
    s = acc_log.size(); c = clr_log.size();
    done = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bufn = 2'(b);
      tick();
    end
    done = 1'b0;
    checks++;
    if (pending !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL q_peak: pending %0d ovf %b required 4 0", pending, overflow);
    end
    wait_pending_zero(600, "q");
    checks++;
    if (acc_log.size() - s != 88) begin
      errors++; $display("FAIL q_word_count: got %0d required 88", acc_log.size() - s);
    end
    for (int e = 0; e < 4; e++) begin
      a = {2'(e), 6'd0};
      checks++;
      if (acc_log[s + 22 * e] !== {1'b0, a, a} ||
          acc_log[s + 22 * e + 21] !== {1'b1, a + 8'd21, a + 8'd21}) begin
        errors++;
        $display("FAIL q_event%0d: first %h last %h", e, acc_log[s + 22 * e],
                 acc_log[s + 22 * e + 21]);
      end
      checks++;
      if (clr_log[c + e] !== (4'b0001 << e)) begin
        errors++; $display("FAIL q_clear%0d: got %b required %b", e, clr_log[c + e],
                           4'b0001 << e);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL q_overflow: got %b required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int s, c, n;
    logic [1:0] bufs [5];
    ready = 1'b1;
    bufs[0] = 2'd0; bufs[1] = 2'd1; bufs[2] = 2'd2; bufs[3] = 2'd3; bufs[4] = 2'd1;
    s = acc_log.size(); c = clr_log.size();
    done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bufn = bufs[k];
      tick();
    end
    done = 1'b0;
    checks++;
    if (overflow !== 1'b1 || pending !== 3'd4) begin
      errors++; $display("FAIL ovf_set: ovf %b pending %0d required 1 4", overflow, pending);
    end
    wait_pending_zero(600, "ovf");
    checks++;
    if (acc_log.size() - s != 88 || clr_log.size() - c != 4) begin
      errors++; $display("FAIL ovf_drop: words %0d clears %0d required 88 4",
                         acc_log.size() - s, clr_log.size() - c);
    end
    checks++;
    if (clr_log[c + 3] !== 4'b1000 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: clear %b ovf %b required 1000 1",
                         clr_log[c + 3], overflow);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_reset: got %b required 0", overflow);
    end
    c = clr_log.size();
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bufn = bufs[k];
      tick();
    end
    done = 1'b0;
    n = 0;
    while (clr === 4'b0000 && n < 200) begin tick(); n++; end
    pulse(2'd1);
    checks++;
    if (pending !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_on_clear: pending %0d ovf %b required 4 0", pending, overflow);
    end
    wait_pending_zero(800, "ovf2");
    checks++;
    if (clr_log.size() - c != 5 || clr_log[c + 4] !== 4'b0010 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_on_clear_drain: clears %0d ovf %b required 5 0",
                         clr_log.size() - c, overflow);
    end
  endtask

  task automatic test_mid_reset();
    int s, c, n;
    ready = 1'b1;
    s = acc_log.size(); c = clr_log.size();
    pulse(2'd2);
    n = 0;
    while (acc_log.size() < s + 7 && n < 200) begin tick(); n++; end
    ready = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (dat !== 16'h8787) begin
      errors++; $display("FAIL mr_word7: got %h required 8787", dat);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending !== 3'd0 || ram_addr !== 8'h00 || dat !== 16'h0000) begin
      errors++; $display("FAIL mr_after: valid %b pending %0d addr %h dat %h required 0 0 00 0000",
                         valid, pending, ram_addr, dat);
    end
    ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (clr_log.size() != c) begin
      errors++; $display("FAIL mr_no_clear: pulses %0d required 0", clr_log.size() - c);
    end
    s = acc_log.size();
    pulse(2'd3);
    tick();
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== 8'hC0) begin
      errors++; $display("FAIL mr_new_fetch: rd %b addr %h required 1 c0", ram_rd, ram_addr);
    end
    wait_pending_zero(200, "mr");
    checks++;
    if (acc_log.size() - s != 22 || acc_log[s] !== {1'b0, 16'hC0C0} ||
        acc_log[s + 21] !== {1'b1, 16'hD5D5}) begin
      errors++; $display("FAIL mr_new_event: words %0d first %h last %h",
                         acc_log.size() - s, acc_log[s], acc_log[s + 21]);
    end
    checks++;
    if (clr_log.size() - c != 1 || clr_log[c] !== 4'b1000) begin
      errors++; $display("FAIL mr_clear: pulses %0d required 1 of 1000", clr_log.size() - c);
    end
  endtask

  task automatic test_single_word();
    logic [1:0] bl [2];
    logic [7:0] a;
    logic [3:0] oh;
    bl[0] = 2'd1; bl[1] = 2'd3;
    ready1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = {bl[k], 6'd0};
      oh = 4'b0001 << bl[k];
      done1 = 1'b1;
      buf1 = bl[k];
      tick();
      done1 = 1'b0;
      tick();
      checks++;
      if (rd1 !== 1'b1 || addr1 !== a) begin
        errors++; $display("FAIL one_fetch%0d: rd %b addr %h required 1 %h", k, rd1, addr1, a);
      end
      tick();
      tick();
      checks++;
      if (valid1 !== 1'b1 || last1 !== 1'b1 || dat1 !== {a, a}) begin
        errors++; $display("FAIL one_word%0d: valid %b last %b dat %h required 1 1 %h",
                           k, valid1, last1, dat1, {a, a});
      end
      tick();
      checks++;
      if (clr1 !== oh || valid1 !== 1'b0) begin
        errors++; $display("FAIL one_clear%0d: clr %b valid %b required %b 0", k, clr1, valid1, oh);
      end
      tick();
      checks++;
      if (clr1 !== 4'b0000 || pending1 !== 3'd0) begin
        errors++; $display("FAIL one_idle%0d: clr %b pending %0d required 0000 0",
                           k, clr1, pending1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_backpressure();
    test_queue_order();
    test_overflow();
    test_mid_reset();
    test_single_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
